lsu_ctrl: RTL and testbench

//  Load/store sequencer between the decoded memory controls (mem_read, mem_write, data_size, data_sign) and the data-memory bus.

---
 rtl/lsu_ctrl_pkg.sv | 36 +++
 rtl/lsu_ctrl_align.sv | 39 +++
 rtl/lsu_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, error causes, FSM states
// and the address-alignment helpers used by lsu_ctrl.
package lsu_ctrl_pkg;

  localparam logic [1:0] LsuSizeByte = 2'b00;
  localparam logic [1:0] LsuSizeHalf = 2'b01;
  localparam logic [1:0] LsuSizeWord = 2'b10;
  localparam logic [1:0] LsuSizeIll  = 2'b11;

  localparam logic [1:0] LsuErrNone     = 2'b00;
  localparam logic [1:0] LsuErrMisalign = 2'b01;
  localparam logic [1:0] LsuErrTimeout  = 2'b10;
  localparam logic [1:0] LsuErrIllsize  = 2'b11;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StResp = 3'd2,
    StDone = 3'd3,
    StErr  = 3'd4
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == LsuSizeHalf) && a[0]) || ((size == LsuSizeWord) && (a != 2'b00));
  endfunction

  // Clears the low address bits that would make the access straddle its natural boundary.
  function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] a);
    case (size)
      LsuSizeHalf: return {a[1], 1'b0};
      LsuSizeWord: return 2'b00;
      default:     return a;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Byte-lane steering for stores and shift/extend of load data; purely combinational.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  a_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // sign_i == 1 selects zero-extension.
  always_comb begin
    shifted = rdata_i >> {a_i, 3'b000};
    case (size_i)
      LsuSizeByte: begin
        be_o    = 4'b0001 << a_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~sign_i & shifted[7]}}, shifted[7:0]};
      end
      LsuSizeHalf: begin
        be_o    = 4'b0011 << {a_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~sign_i & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = shifted;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one data-bus transaction per memory op, stalling the pipeline until done.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           data_size,
  input  logic                 data_sign,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic                 stall,
  output logic [WORD_SIZE-1:0] load_data,
  output logic                 load_valid,
  output logic                 err,
  output logic [1:0]           err_cause,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [WORD_SIZE-1:0] bus_addr,
  output logic [3:0]           bus_be,
  output logic [WORD_SIZE-1:0] bus_wdata,
  input  logic                 bus_gnt,
  input  logic                 bus_rvalid,
  input  logic [WORD_SIZE-1:0] bus_rdata
);

  lsu_state_e state_q, state_d;

  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] load_data_q, load_data_d;
  logic [1:0]           size_q, size_d;
  logic [1:0]           cause_q, cause_d;
  logic                 sign_q, sign_d;
  logic                 we_q, we_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;

  logic                 accept;
  logic                 timeout_go;
  logic [3:0]           align_be;
  logic [WORD_SIZE-1:0] align_wdata;
  logic [WORD_SIZE-1:0] align_rdata;

  assign accept = req_valid & (mem_read | mem_write);

  // Expire only when the current phase made no progress this cycle.
  assign timeout_go = (cnt_q >= TO_W'(TIMEOUT_CYCLES - 1)) &
                      (((state_q == StReq) & ~bus_gnt) | ((state_q == StResp) & ~bus_rvalid));

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = is_misaligned(data_size, addr[1:0]);
`endif

  lsu_align u_align (
    .size_i  (size_q),
    .sign_i  (sign_q),
    .a_i     (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (bus_rdata),
    .be_o    (align_be),
    .wdata_o (align_wdata),
    .rdata_o (align_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (data_size == LsuSizeIll) begin
            state_d = StErr;
`ifdef LSU_MISALIGN_TRAP_EN
          end else if (misaligned) begin
            state_d = StErr;
`endif
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (bus_gnt)         state_d = StResp;
        else if (timeout_go) state_d = StErr;
      end
      StResp: begin
        if (bus_rvalid)      state_d = StDone;
        else if (timeout_go) state_d = StErr;
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      size_q      <= '0;
      cause_q     <= '0;
      sign_q      <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      size_q      <= size_d;
      cause_q     <= cause_d;
      sign_q      <= sign_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    size_d      = size_q;
    cause_d     = cause_q;
    sign_d      = sign_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = addr;
`ifndef LSU_MISALIGN_TRAP_EN
          addr_d[1:0] = force_align(data_size, addr[1:0]);
`endif
          wdata_d = wdata;
          size_d  = data_size;
          sign_d  = data_sign;
          we_d    = mem_write;
          cnt_d   = '0;
          cause_d = LsuErrNone;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned) cause_d = LsuErrMisalign;
`endif
          if (data_size == LsuSizeIll) cause_d = LsuErrIllsize;
        end
      end
      StReq, StResp: begin
        cnt_d = cnt_q + TO_W'(1);
        if (timeout_go) cause_d = LsuErrTimeout;
        if ((state_q == StResp) && bus_rvalid) load_data_d = align_rdata;
      end
      default: ;
    endcase
  end

  // Bus fields are gated so the bus is quiet whenever no request is outstanding.
  always_comb begin
    bus_req    = (state_q == StReq);
    bus_we     = bus_req & we_q;
    bus_addr   = bus_req ? {addr_q[WORD_SIZE-1:2], 2'b00} : '0;
    bus_be     = bus_req ? align_be : 4'b0000;
    bus_wdata  = bus_req ? align_wdata : '0;
    load_valid = (state_q == StDone);
    err        = (state_q == StErr);
    err_cause  = err ? cause_q : 2'b00;
    load_data  = load_data_q;
    stall      = req_valid & ~load_valid & ~err;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: random and directed memory ops against a byte-level reference model.
module tb_lsu_ctrl;

  localparam int unsigned TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, data_sign = 1'b0;
  logic [1:0]  data_size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall, load_valid, err, bus_req, bus_we;
  logic [1:0]  err_cause;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  lsu_ctrl #(.WORD_SIZE(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .data_size  (data_size),
    .data_sign  (data_sign),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .err        (err),
    .err_cause  (err_cause),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    bit         is_err;
    logic [1:0] cause;
    bit         is_load;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  // Bus responder configuration and expected bus fields, written only by the stimulus.
  int          cfg_gdly = 0, cfg_rdly = 0;
  bit          cfg_no_rv = 1'b0;
  logic [31:0] cfg_rdata = '0;
  bit          exp_bus = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_be = '0;
  int          force_req = 0;

  // Reference model: works on byte counts and offsets rather than encoded lanes.
  function automatic void model(input bit wr, input logic [1:0] size, input bit sign,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, output exp_t e, output bit uses_bus,
                                output logic [31:0] b_addr, output logic [3:0] b_be,
                                output logic [31:0] b_wdata);
    int unsigned nbytes, off;
    logic [31:0] eff, mask, v;
    e.is_err = 1'b0; e.cause = 2'b00; e.is_load = !wr; e.data = '0;
    uses_bus = 1'b0; b_addr = '0; b_be = '0; b_wdata = '0;
    if (size == 2'b11) begin
      e.is_err = 1'b1; e.cause = 2'b11;
      return;
    end
    nbytes = 1 << size;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((a % nbytes) != 0) begin
      e.is_err = 1'b1; e.cause = 2'b01;
      return;
    end
`endif
    eff = a - (a % nbytes);
    off = eff % 4;
    uses_bus = 1'b1;
    b_addr = eff - off;
    b_be = 4'(((1 << nbytes) - 1) << off);
    for (int i = 0; i < 4; i++) b_wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 1);
    v = (rd >> (8 * off)) & mask;
    if (!sign && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
    e.data = v;
  endfunction

  // Bus responder: grants after cfg_gdly wait cycles, answers after cfg_rdly more.
  initial begin
    int req_cnt = 0;
    int rv_cnt = 0;
    int force_seen = 0;
    bit wait_rv = 1'b0;
    forever begin
      @(negedge clk);
      bus_gnt = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata = $urandom;
      if (err || load_valid) wait_rv = 1'b0;
      if (!rst_n) begin
        wait_rv = 1'b0;
        req_cnt = 0;
      end else if (force_req != force_seen) begin
        force_seen = force_req;
        bus_rvalid = 1'b1;
      end else if (bus_req) begin
        wait_rv = 1'b0;
        check("bus_req_allowed", 32'(bus_req), 32'(exp_bus));
        if (exp_bus) begin
          check("bus_addr", bus_addr, exp_addr);
          check("bus_be", 32'(bus_be), 32'(exp_be));
          check("bus_we", 32'(bus_we), 32'(exp_we));
          if (exp_we) check("bus_wdata", bus_wdata, exp_wdata);
        end
        if (req_cnt >= cfg_gdly) begin
          bus_gnt = 1'b1;
          req_cnt = 0;
          wait_rv = 1'b1;
          rv_cnt = 0;
        end else begin
          req_cnt++;
        end
      end else if (wait_rv) begin
        if (!cfg_no_rv && rv_cnt == cfg_rdly) begin
          bus_rvalid = 1'b1;
          bus_rdata = cfg_rdata;
          wait_rv = 1'b0;
        end else begin
          rv_cnt++;
        end
      end
    end
  end

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  initial begin
    bit prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (load_valid || err)) begin
        check("single_cycle_pulse", 32'(prev_done), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_completion: load_valid=%0b err=%0b with empty scoreboard",
                   load_valid, err);
        end else begin
          e = sb.pop_front();
          check("completion_kind_err", 32'(err), 32'(e.is_err));
          check("completion_kind_lv", 32'(load_valid), 32'(!e.is_err));
          if (e.is_err) check("err_cause", 32'(err_cause), 32'(e.cause));
          else if (e.is_load) check("load_data", load_data, e.data);
        end
      end
      prev_done = rst_n && (load_valid || err);
    end
  end

  // Issues one op at posedge+1, checks stall and completion latency, returns at posedge+1.
  task automatic run_op(input bit rd, input bit wr, input logic [1:0] size, input bit sign,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                        input int gdly, input int rdly, input bit no_rv);
    exp_t e;
    bit ub, done;
    logic [31:0] ba, bw;
    logic [3:0] bb;
    int lat;
    model(wr, size, sign, a, wd, rdv, e, ub, ba, bb, bw);
    if (no_rv && ub) begin
      e.is_err = 1'b1;
      e.cause = 2'b10;
    end
    lat = !ub ? 1 : (no_rv ? int'(TIMEOUT) + 1 : gdly + rdly + 3);
    cfg_gdly = gdly; cfg_rdly = rdly; cfg_no_rv = no_rv; cfg_rdata = rdv;
    exp_bus = ub; exp_addr = ba; exp_be = bb; exp_wdata = bw; exp_we = wr;
    sb.push_back(e);
    req_valid = 1'b1; mem_read = rd; mem_write = wr;
    data_size = size; data_sign = sign; addr = a; wdata = wd;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (load_valid || err) begin
        done = 1'b1;
        check("stall_on_done", 32'(stall), 32'd0);
        check("latency", 32'(k), 32'(lat));
      end else begin
        check("stall_busy", 32'(stall), 32'd1);
        if (k >= 1) begin
          // Captured fields must ignore input changes after the accept edge.
          addr = $urandom; wdata = $urandom;
          data_size = 2'($urandom); data_sign = 1'($urandom);
        end
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL op_timeout: no completion within 200 cycles, expected latency %0d", lat);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    exp_bus = 1'b0;
  endtask

  initial begin
    exp_t e;
    bit ub, r_rd, r_wr;
    logic [31:0] ba, bw;
    logic [3:0] bb;
    logic [1:0] r_size;

    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cause", 32'(err_cause), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LB signed at the top byte lane, immediate gnt/rvalid.
    run_op(1, 0, 2'b00, 0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0, 0);
    // SH to the upper half.
    run_op(0, 1, 2'b01, 0, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0, 0, 0);
    // LW with a slow grant: bus_req held 6 cycles.
    run_op(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 5, 1, 0);
    // LW that never gets a response.
    run_op(1, 0, 2'b10, 0, 32'h0000_0200, 32'h0, 32'h0, 0, 0, 1);
    force_req++;
    repeat (3) @(posedge clk);
    #1;
    run_op(1, 0, 2'b10, 1, 32'h0000_0204, 32'h0, 32'h1357_9BDF, 0, 0, 0);
    // Misaligned word: trapped or force-aligned depending on the build.
    run_op(1, 0, 2'b10, 0, 32'h0000_3001, 32'h0, 32'h8765_4321, 0, 0, 0);
    run_op(1, 0, 2'b01, 0, 32'h0000_3003, 32'h0, 32'h8765_4321, 1, 0, 0);
    // Illegal size.
    run_op(0, 1, 2'b11, 0, 32'h0000_4000, 32'h1111_2222, 32'h0, 0, 0, 0);

    // Reset in the middle of RESP.
    model(0, 2'b10, 0, 32'h0000_0040, 32'h0, 32'h0, e, ub, ba, bb, bw);
    cfg_gdly = 0; cfg_rdly = 20; cfg_no_rv = 1'b0;
    exp_bus = ub; exp_addr = ba; exp_be = bb; exp_wdata = bw; exp_we = 1'b0;
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; data_size = 2'b10;
    data_sign = 1'b0; addr = 32'h0000_0040;
    repeat (3) @(negedge clk);
    check("resp_stall_before_rst", 32'(stall), 32'd1);
    #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rst_mid_bus_req", 32'(bus_req), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_load_valid", 32'(load_valid), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    exp_bus = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(1, 0, 2'b00, 1, 32'h0000_0010, 32'h0, 32'h0000_00AA, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_rd = !r_wr || 1'($urandom_range(0, 1));
      r_size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_op(r_rd, r_wr, r_size, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
